// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if
// Bundles the user-side value/strobe inputs and the decoder/digit-pin
// outputs of the seven-segment scan controller.
//   data_in    : display value, nibble k drives digit k (digit 0 = LS nibble)
//   dp_in      : decimal-point request per digit
//   load       : one-cycle strobe capturing data_in/dp_in into the shadow copy
//   lz_blank   : leading-zero suppression enable
//   comAnode   : display polarity, also fed to the decoder
//   nibble_out : nibble presented to the shared decoder
//   dp_out     : decimal-point segment, polarity adjusted
//   digit_en   : one-hot digit drive, active level = comAnode
//   frame_done : one-cycle pulse when the scan wraps back to digit 0
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank;
  logic                    comAnode;
  logic [3:0]              nibble_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  // User logic / bench side.
  modport master (
    output data_in, dp_in, load, lz_blank, comAnode,
    input  nibble_out, dp_out, digit_en, frame_done
  );

  // Scan controller side.
  modport slave (
    input  data_in, dp_in, load, lz_blank, comAnode,
    output nibble_out, dp_out, digit_en, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
// Time-multiplexes one shared nibble-to-segment decoder over NUM_DIGITS
// common-wired digits. Each digit gets a fixed slot of DIGIT_CYCLES clocks:
// BLANK_CYCLES with every digit off (the decoder settles on the new nibble),
// then SHOW with that digit driven. A shadow copy of the value is loaded by
// the user at any time and moved to the active copy only at frame wrap.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sevenseg_scan_ctrl_if.slave (value/strobe in, decoder/pins out)
// DEC_LATENCY must be at least 1; digit_en/dp_out are delayed by that many
// clocks so they line up with the decoder's registered segment output.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 12000,
  parameter int BLANK_CYCLES = 64,
  parameter int DEC_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sevenseg_scan_ctrl_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_e;

  state_e                  state_q;
  logic [4*NUM_DIGITS-1:0] shadowData_q, activeData_q;
  logic [NUM_DIGITS-1:0]   shadowDp_q, activeDp_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              nibble_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    dpOn_q;
  logic                    frameDone_q;
  logic [NUM_DIGITS-1:0]   enPipe_q [DEC_LATENCY];
  logic                    dpPipe_q [DEC_LATENCY];

  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   enShow_d;
  logic [3:0]              nibble_d;
  logic                    lastSlot;
  logic                    frameWrap;

  // A digit above 0 is blanked when it and every more significant nibble
  // of the active value are zero; digit 0 always shows.
  always_comb begin
    suppress = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      suppress[k] = bus.lz_blank && ((activeData_q >> (4 * k)) == '0);
    end
  end

  // Enable pattern to load on entry to SHOW, and the nibble for this slot.
  always_comb begin
    enShow_d        = '0;
    enShow_d[idx_q] = ~suppress[idx_q];
    nibble_d        = activeData_q[{idx_q, 2'b00} +: 4];
  end

  assign lastSlot  = (cnt_q == LAST_CNT);
  assign frameWrap = lastSlot && (idx_q == LAST_IDX);

  // Slot sequencer: counts through BLANK then SHOW for the current digit,
  // advances the digit index at slot end and refreshes the active copy only
  // when the index wraps, so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      shadowData_q <= '0;
      shadowDp_q   <= '0;
      activeData_q <= '0;
      activeDp_q   <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      nibble_q     <= '0;
      en_q         <= '0;
      dpOn_q       <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        shadowData_q <= bus.data_in;
        shadowDp_q   <= bus.dp_in;
      end
      // Non-blocking read of the shadow: a load on the wrap edge is seen
      // only at the following frame.
      if (frameWrap) begin
        activeData_q <= shadowData_q;
        activeDp_q   <= shadowDp_q;
      end
      frameDone_q <= frameWrap;

      if (cnt_q == '0) begin
        nibble_q <= nibble_d;
      end

      if (lastSlot) begin
        cnt_q   <= '0;
        idx_q   <= frameWrap ? '0 : idx_q + 1'b1;
        state_q <= BLANK;
        en_q    <= '0;
        dpOn_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == BLANK && cnt_q == LAST_BLANK) begin
          state_q <= SHOW;
          en_q    <= enShow_d;
          dpOn_q  <= activeDp_q[idx_q];
        end
      end
    end
  end

  // Delay line matching the decoder pipeline so pins switch with segout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEC_LATENCY; i++) begin
        enPipe_q[i] <= '0;
        dpPipe_q[i] <= 1'b0;
      end
    end else begin
      enPipe_q[0] <= en_q;
      dpPipe_q[0] <= dpOn_q;
      for (int i = 1; i < DEC_LATENCY; i++) begin
        enPipe_q[i] <= enPipe_q[i-1];
        dpPipe_q[i] <= dpPipe_q[i-1];
      end
    end
  end

  // Polarity is applied combinationally so comAnode takes effect at once.
  assign bus.nibble_out = nibble_q;
  assign bus.digit_en   = ~(enPipe_q[DEC_LATENCY-1] ^ {NUM_DIGITS{bus.comAnode}});
  assign bus.dp_out     = ~(dpPipe_q[DEC_LATENCY-1] ^ bus.comAnode);
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl
// Self-checking bench for sevenseg_scan_ctrl with NUM_DIGITS=4,
// DIGIT_CYCLES=16, BLANK_CYCLES=4, DEC_LATENCY=2. Frame-relative sample
// points: n=0 is the negedge where frame_done is seen; digit d's slot
// starts at n=16d, its nibble is valid from offset 1 and its enable is
// active on offsets 6..17.
module tb_sevenseg_scan_ctrl;
  localparam int ND = 4;
  localparam int DC = 16;
  localparam int BC = 4;
  localparam int DL = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic        cA;
    logic [15:0] expNibs;
    logic [3:0]  expEn;
    logic [3:0]  expDp;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] prevNibs;

  sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .DEC_LATENCY (DL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive user inputs at a negedge; optionally pulse load for one cycle.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp,
                               input logic lz, input logic cA, input logic doLoad);
    bus.data_in  = data;
    bus.dp_in    = dp;
    bus.lz_blank = lz;
    bus.comAnode = cA;
    if (doLoad) begin
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
    end
  endtask

  task automatic waitNeg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Bounded wait for the next frame_done pulse.
  task automatic waitFrame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("frame_done_seen", 16'(seen), 16'd1);
  endtask

  function automatic logic [3:0] expectEn(input int d, input logic cA, input logic on);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    if (!on) return {4{~cA}};
    return cA ? oh : ~oh;
  endfunction

  // Walk one whole frame from n=1 to n=65, checking nibble, blanking,
  // enables, dp and frame_done at the slot-relative sample points.
  task automatic checkFrame(input logic [15:0] expNibs, input logic [3:0] enMask,
                            input logic [3:0] dpMask, input logic cA);
    logic       actBit;
    logic       idleBit;
    logic [3:0] idleEn;
    actBit  = cA;
    idleBit = ~cA;
    idleEn  = {4{~cA}};
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      if (n == 32) checkOutput("frame_done_mid", 16'(bus.frame_done), 16'd0);
      if (n == 64) checkOutput("frame_done_period", 16'(bus.frame_done), 16'd1);
      for (int d = 0; d < 4; d++) begin
        int off;
        off = n - 16 * d;
        if (off == 2) begin
          checkOutput($sformatf("nibble_d%0d", d), 16'(bus.nibble_out), 16'(expNibs[15-4*d -: 4]));
          checkOutput($sformatf("blank_en_d%0d", d), 16'(bus.digit_en), 16'(idleEn));
        end
        if (off == 5) begin
          checkOutput($sformatf("pre_show_en_d%0d", d), 16'(bus.digit_en), 16'(idleEn));
          checkOutput($sformatf("pre_show_dp_d%0d", d), 16'(bus.dp_out), 16'(idleBit));
        end
        if (off == 6 || off == 17) begin
          checkOutput($sformatf("show_en_d%0d_off%0d", d, off), 16'(bus.digit_en),
                      16'(expectEn(d, cA, enMask[d])));
          checkOutput($sformatf("show_dp_d%0d_off%0d", d, off), 16'(bus.dp_out),
                      16'(dpMask[d] ? actBit : idleBit));
        end
      end
    end
  endtask

  // Release reset at a negedge and check the first partial frame:
  // digit 0 enabled at r=6, first frame_done exactly at r=64.
  task automatic releaseAndCheck();
    logic early;
    early = 1'b0;
    rst_n = 1'b1;
    for (int r = 1; r <= 64; r++) begin
      @(negedge clk);
      if (r < 64 && bus.frame_done) early = 1'b1;
      if (r == 5) checkOutput("release_blank_en", 16'(bus.digit_en), 16'h0);
      if (r == 6) begin
        checkOutput("release_first_digit", 16'(bus.digit_en), 16'h1);
        checkOutput("release_nibble", 16'(bus.nibble_out), 16'h0);
      end
      if (r == 64) checkOutput("release_first_frame_done", 16'(bus.frame_done), 16'd1);
    end
    checkOutput("release_no_early_frame_done", 16'(early), 16'd0);
  endtask

  initial begin
    vecs[0] = '{data:16'h12A4, dp:4'b0000, lz:1'b0, cA:1'b1, expNibs:16'h4A21, expEn:4'b1111, expDp:4'b0000};
    vecs[1] = '{data:16'h0030, dp:4'b0000, lz:1'b1, cA:1'b1, expNibs:16'h0300, expEn:4'b0011, expDp:4'b0000};
    vecs[2] = '{data:16'h0000, dp:4'b0100, lz:1'b0, cA:1'b0, expNibs:16'h0000, expEn:4'b1111, expDp:4'b0100};
    vecs[3] = '{data:16'h0000, dp:4'b0000, lz:1'b1, cA:1'b1, expNibs:16'h0000, expEn:4'b0001, expDp:4'b0000};
    vecs[4] = '{data:16'h8005, dp:4'b1000, lz:1'b1, cA:1'b1, expNibs:16'h5008, expEn:4'b1111, expDp:4'b1000};
    vecs[5] = '{data:16'h0700, dp:4'b1000, lz:1'b1, cA:1'b1, expNibs:16'h0070, expEn:4'b0111, expDp:4'b1000};

    rst_n    = 1'b0;
    bus.load = 1'b0;
    applyStimulus(16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    waitNeg(3);
    checkOutput("reset_digit_en", 16'(bus.digit_en), 16'h0);
    checkOutput("reset_nibble", 16'(bus.nibble_out), 16'h0);
    checkOutput("reset_dp_out", 16'(bus.dp_out), 16'h0);
    checkOutput("reset_frame_done", 16'(bus.frame_done), 16'h0);
    bus.comAnode = 1'b0;
    #1;
    checkOutput("reset_digit_en_ca0", 16'(bus.digit_en), 16'hF);
    checkOutput("reset_dp_out_ca0", 16'(bus.dp_out), 16'h1);
    bus.comAnode = 1'b1;
    @(negedge clk);

    releaseAndCheck();
    checkFrame(16'h0000, 4'b1111, 4'b0000, 1'b1);

    // Table: load mid-frame, confirm the old value still shows, then check
    // the whole next frame.
    prevNibs = 16'h0000;
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].data, vecs[v].dp, vecs[v].lz, vecs[v].cA, 1'b1);
      waitNeg(20);
      checkOutput($sformatf("hold_until_frame_v%0d", v), 16'(bus.nibble_out), 16'(prevNibs[11:8]));
      waitFrame();
      checkFrame(vecs[v].expNibs, vecs[v].expEn, vecs[v].expDp, vecs[v].cA);
      prevNibs = vecs[v].expNibs;
    end

    // Load coincident with the frame-boundary edge.
    applyStimulus(16'h1111, 4'b0000, 1'b0, 1'b1, 1'b1);
    waitNeg(61);
    applyStimulus(16'hFFFF, 4'b0100, 1'b0, 1'b1, 1'b1);
    checkOutput("boundary_frame_done", 16'(bus.frame_done), 16'd1);
    checkFrame(16'h1111, 4'b1111, 4'b0000, 1'b1);
    waitFrame();
    checkFrame(16'hFFFF, 4'b1111, 4'b0100, 1'b1);

    // Asynchronous reset in the middle of digit 2's SHOW window.
    waitNeg(41);
    checkOutput("pre_reset_digit_en", 16'(bus.digit_en), 16'h4);
    checkOutput("pre_reset_dp_out", 16'(bus.dp_out), 16'h1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_digit_en", 16'(bus.digit_en), 16'h0);
    checkOutput("async_reset_dp_out", 16'(bus.dp_out), 16'h0);
    checkOutput("async_reset_nibble", 16'(bus.nibble_out), 16'h0);
    checkOutput("async_reset_frame_done", 16'(bus.frame_done), 16'h0);
    waitNeg(2);
    releaseAndCheck();
    checkFrame(16'h0000, 4'b1111, 4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexes one shared nibble-to-segment decoder across NUM_DIGITS common-wired seven-segment digits.
- Holds a shadow/active copy of the display value and sequences a per-digit BLANK/SHOW cycle.
- Presents one nibble at a time to the decoder and drives digit enables aligned to the decoder's registered output.
- Sits between user logic (value + load strobe) and the decoder/digit pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 2..8.
- DIGIT_CYCLES, 12000: clk cycles per digit slot (BLANK + SHOW); must be > BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits off (anti-ghosting); must be >= DEC_LATENCY.
- DEC_LATENCY, 2: pipeline depth of the downstream decoder (input nibble to segout).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  4*NUM_DIGITS  display value; nibble k = digit k; digit 0 = least significant
- dp_in  in  NUM_DIGITS  decimal-point request per digit
- load  in  1  one-cycle strobe: capture data_in/dp_in into shadow
- lz_blank  in  1  enable leading-zero suppression
- comAnode  in  1  display polarity; same signal feeds the decoder
- nibble_out  out  4  nibble presented to the decoder
- dp_out  out  1  decimal-point segment, polarity-adjusted, aligned with digit_en
- digit_en  out  NUM_DIGITS  one-hot digit drive; active level = comAnode
- frame_done  out  1  one-cycle pulse after the last digit's SHOW ends

Behaviour:
- Reset (rst_n low, async): shadow = 0, active = 0, digit index = 0, slot counter = 0, state = BLANK.
  - Internal enable register = 0, so digit_en = all ~comAnode.
  - nibble_out = 0; dp_out = inactive (~comAnode); frame_done = 0.
- Deassertion is sampled synchronously; the first BLANK slot for digit 0 starts on the first clk edge after release.
- load: shadow <= {data_in, dp_in} on the same edge. Shadow copies to active only at the frame boundary (digit index wraps NUM_DIGITS-1 -> 0), never mid-frame.
  - load coincident with the boundary edge: the new value goes to shadow only. Active takes the pre-load shadow; the new value displays next frame.
- FSM per slot, slot counter 0..DIGIT_CYCLES-1:
  - BLANK (counter 0..BLANK_CYCLES-1): enable register = 0. nibble_out = active nibble[index], registered at counter==0, so the decoder settles before SHOW.
  - SHOW (counter BLANK_CYCLES..DIGIT_CYCLES-1): enable register bit[index] = 1 unless the digit is suppressed. dp_out = dp[index] XNOR comAnode (i.e. dp active level = comAnode).
  - At counter DIGIT_CYCLES-1: counter -> 0, index -> index+1 mod NUM_DIGITS, state -> BLANK.
  - When index wraps, frame_done = 1 for exactly that cycle, and the active <= shadow update happens on the same edge.
- Leading-zero suppression, when lz_blank = 1: digit k (k > 0) is suppressed if nibbles k..NUM_DIGITS-1 of active are all 0.
  - Digit 0 is never suppressed, so value 0 shows "0".
  - A suppressed digit still consumes its full slot (constant refresh rate). Its enable stays 0 and dp_out stays inactive unless dp[k] = 1.
- Alignment: digit_en and dp_out are delayed internally so they change together with the decoder's segout, i.e. DEC_LATENCY cycles after the corresponding counter edge.
- digit_en = enable register XNOR {NUM_DIGITS{comAnode}}, so it is combinational on polarity only.
- comAnode changing mid-operation takes effect immediately on digit_en/dp_out. No state change, no glitch filtering required.
- At most one digit_en bit is ever active. All bits are inactive throughout BLANK.

Test Plan (NUM_DIGITS=4, DIGIT_CYCLES=16, BLANK_CYCLES=4, DEC_LATENCY=2, comAnode=1):
- Reset released, no load -> digit_en = 4'b0000 during reset. Scan cycles index 0,1,2,3 with nibble_out = 0. frame_done pulses every 64 cycles. Each digit_en bit is high for exactly 12 cycles, starting 4+2 cycles into its slot.
- load with data_in=16'h12A4 mid-frame -> display unchanged until frame_done. Next frame: nibble_out sequence 4,A,2,1, with digit_en one-hot 0001,0010,0100,1000.
- lz_blank=1, data_in=16'h0030, load -> digits 3 and 2 are never enabled. Digit 1 shows 3; digit 0 shows 0. Slot timing is unchanged (frame_done still every 64 cycles).
- comAnode=0, dp_in=4'b0100, data_in=16'h0000 -> digit_en active bits read 0 (idle 1111). dp_out = 0 only during digit 2's SHOW window, 1 otherwise.
- load on the exact frame-boundary edge with 16'hFFFF (previous shadow 16'h1111) -> next frame shows 1111, following frame shows FFFF.
- rst_n pulled low mid-SHOW of digit 2 -> digit_en and dp_out go inactive asynchronously, shadow/active clear. After release, the scan restarts at digit 0 BLANK.
